// File: rtl/foc_sched_pkg.sv
// Shared types and constants for the FOC loop scheduler and its parameter bank.
package foc_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BUSY  = 2'd2,
    ST_FAULT = 2'd3
  } foc_state_e;

  localparam int unsigned DONE_TIMEOUT_DEF = 64;

  localparam logic [2:0] CFG_P_GAIN         = 3'd0;
  localparam logic [2:0] CFG_I_GAIN         = 3'd1;
  localparam logic [2:0] CFG_MAX_V          = 3'd2;
  localparam logic [2:0] CFG_CURRENT_TARGET = 3'd3;
  localparam logic [2:0] CFG_MAX_WINDUP     = 3'd4;
  localparam logic [2:0] CFG_STATOR_OFFSET  = 3'd5;

  typedef struct packed {
    logic [15:0] p_gain;
    logic [15:0] i_gain;
    logic [15:0] max_v;
    logic [15:0] current_target;
    logic [31:0] max_windup;
    logic [10:0] stator_offset;
  } foc_params_t;

endpackage

// File: rtl/foc_param_bank.sv
// Shadow/live loop parameters; the whole shadow set is copied to live in one cycle
// at the first apply point after a commit request.
module foc_param_bank
  import foc_sched_pkg::*;
(
  input  logic        c,
  input  logic        rst,
  input  logic        cfg_wr_i,
  input  logic [2:0]  cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  input  logic        cfg_commit_i,
  input  logic        apply_i,
  output foc_params_t live_o,
  output logic        commit_pending_o
);

  foc_params_t shadow_q, shadow_d;
  foc_params_t live_q, live_d;
  logic        pending_q, pending_d;
  logic        copy;

  assign copy = pending_q && apply_i;

  always_comb begin
    shadow_d = shadow_q;
    if (cfg_wr_i) begin
      case (cfg_addr_i)
        CFG_P_GAIN:         shadow_d.p_gain         = cfg_wdata_i[15:0];
        CFG_I_GAIN:         shadow_d.i_gain         = cfg_wdata_i[15:0];
        CFG_MAX_V:          shadow_d.max_v          = cfg_wdata_i[15:0];
        CFG_CURRENT_TARGET: shadow_d.current_target = cfg_wdata_i[15:0];
        CFG_MAX_WINDUP:     shadow_d.max_windup     = cfg_wdata_i;
        CFG_STATOR_OFFSET:  shadow_d.stator_offset  = cfg_wdata_i[10:0];
        default: ;
      endcase
    end
  end

  // A commit arriving in the apply cycle itself stays pending for the next apply point.
  always_comb begin
    live_d    = copy ? shadow_q : live_q;
    pending_d = cfg_commit_i ? 1'b1 : (copy ? 1'b0 : pending_q);
  end

  always_ff @(posedge c) begin
    if (rst) begin
      shadow_q  <= '0;
      live_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      live_q    <= live_d;
      pending_q <= pending_d;
    end
  end

  assign live_o           = live_q;
  assign commit_pending_o = pending_q;

endmodule

// File: rtl/foc_sched.sv
// Current-loop scheduler: hands ADC samples to the FOC datapath, watches for its
// completion, counts dropped samples and gates parameter updates to safe points.
module foc_sched
  import foc_sched_pkg::*;
#(
  parameter int unsigned DONE_TIMEOUT = DONE_TIMEOUT_DEF,
  parameter int unsigned OVR_W        = 16
) (
  input  logic             c,
  input  logic             rst,
  input  logic             en,
  input  logic             adc_dv,
  input  logic [47:0]      adc_d,
  output logic [47:0]      foc_i_d,
  output logic             foc_i_dv,
  input  logic             foc_done,
  output logic             foc_active,
  input  logic             cfg_wr,
  input  logic [2:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  input  logic             cfg_commit,
  output logic [15:0]      p_gain,
  output logic [15:0]      i_gain,
  output logic [15:0]      max_v,
  output logic [15:0]      current_target,
  output logic [31:0]      max_windup,
  output logic [10:0]      stator_offset,
  output logic             commit_pending,
  output logic             fault,
  output logic             busy,
  output logic [OVR_W-1:0] overrun_cnt
);

  localparam int unsigned TMR_W = $clog2(DONE_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DONE_TIMEOUT - 1);

  foc_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [47:0]      sample_q, sample_d;
  logic             dv_q, dv_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;
  logic             apply;
  foc_params_t      live;

  // Disable wins over everything; completion wins over a same-cycle timeout or overrun.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    sample_d = sample_q;
    dv_d     = 1'b0;
    ovr_d    = ovr_q;
    apply    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        apply = 1'b1;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (adc_dv) begin
          sample_d = adc_d;
          dv_d     = 1'b1;
          timer_d  = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (adc_dv && (ovr_q != '1)) ovr_d = ovr_q + 1'b1;
        if (!en) begin
          state_d = ST_IDLE;
        end else if (foc_done) begin
          state_d = ST_RUN;
          apply   = 1'b1;
        end else if (timer_q == TMR_LAST) begin
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_FAULT: begin
        apply = 1'b1;
        if (!en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge c) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      sample_q <= '0;
      dv_q     <= 1'b0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      sample_q <= sample_d;
      dv_q     <= dv_d;
      ovr_q    <= ovr_d;
    end
  end

  foc_param_bank u_bank (
    .c                (c),
    .rst              (rst),
    .cfg_wr_i         (cfg_wr),
    .cfg_addr_i       (cfg_addr),
    .cfg_wdata_i      (cfg_wdata),
    .cfg_commit_i     (cfg_commit),
    .apply_i          (apply),
    .live_o           (live),
    .commit_pending_o (commit_pending)
  );

  assign foc_i_d        = sample_q;
  assign foc_i_dv       = dv_q;
  assign foc_active     = (state_q == ST_RUN) || (state_q == ST_BUSY);
  assign busy           = (state_q == ST_BUSY);
  assign fault          = (state_q == ST_FAULT);
  assign overrun_cnt    = ovr_q;
  assign p_gain         = live.p_gain;
  assign i_gain         = live.i_gain;
  assign max_v          = live.max_v;
  assign current_target = live.current_target;
  assign max_windup     = live.max_windup;
  assign stator_offset  = live.stator_offset;

endmodule

// File: doc/foc_sched.md
FOC_SCHED -- requirements
Module: foc_sched

Interface
REQ-001 Parameter: DONE_TIMEOUT, default 64, max cycles from foc_i_dv to foc_done before fault.
REQ-002 Parameter: OVR_W, default 16, width of overrun counter.
REQ-003 c  in  1  sole clock; all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 en  in  1  host enable for current loop.
REQ-006 adc_dv  in  1  one-cycle pulse, new phase-current sample.
REQ-007 adc_d  in  48  three packed 16-bit current samples.
REQ-008 foc_i_d  out  48  registered sample to FOC datapath.
REQ-009 foc_i_dv  out  1  one-cycle start pulse to FOC datapath.
REQ-010 foc_done  in  1  one-cycle pulse, FOC PWM outputs updated.
REQ-011 foc_active  out  1  FOC active flag (datapath clears integrators on its rise).
REQ-012 cfg_wr  in  1  shadow-register write strobe.
REQ-013 cfg_addr  in  3  0 p_gain, 1 i_gain, 2 max_v, 3 current_target, 4 max_windup, 5 stator_offset, 6-7 ignored.
REQ-014 cfg_wdata  in  32  write data, low bits used per target width.
REQ-015 cfg_commit  in  1  request to apply shadow set atomically.
REQ-016 p_gain, i_gain, max_v, current_target  out  16 each  live parameters.
REQ-017 max_windup  out  32; stator_offset  out  11  live parameters.
REQ-018 commit_pending  out  1; fault  out  1; busy  out  1; overrun_cnt  out  OVR_W.

Function
REQ-019 FSM states IDLE, RUN (waiting for sample), BUSY (FOC computing), FAULT.
REQ-020 IDLE->RUN when en=1; foc_active rises the same edge the state enters RUN.
REQ-021 RUN with adc_dv: latch adc_d into foc_i_d, pulse foc_i_dv next cycle (1-cycle latency), enter BUSY.
REQ-022 BUSY with foc_done: return to RUN; busy=1 only in BUSY.
REQ-023 BUSY timer counts from 0 at entry; reaching DONE_TIMEOUT without foc_done -> FAULT.
REQ-024 FAULT: fault=1, foc_active=0; exit to IDLE only when en=0.
REQ-025 en=0 in RUN or BUSY -> IDLE next cycle, foc_active=0; foc_done arriving in IDLE/FAULT ignored.
REQ-026 adc_dv while BUSY: sample dropped, no foc_i_dv, overrun_cnt +1 saturating at all-ones.
REQ-027 adc_dv and foc_done same cycle in BUSY: return to RUN, sample dropped, overrun counted.
REQ-028 adc_dv in IDLE/FAULT ignored, not counted.
REQ-029 cfg_wr updates only the shadow register at cfg_addr; live outputs unchanged.
REQ-030 cfg_commit sets commit_pending; shadow->live copy of all six registers happens in one cycle at the next apply point.
REQ-031 Apply points: any cycle in IDLE or FAULT; the BUSY->RUN transition cycle; never while BUSY otherwise.
REQ-032 Apply clears commit_pending; cfg_wr in the apply cycle lands in shadow after the copy (not applied).
REQ-033 cfg_commit coincident with an apply cycle: pending remains set, applied at next apply point.
REQ-034 foc_i_d holds last latched sample; foc_i_dv never high two consecutive cycles.

Reset
REQ-035 rst: state IDLE, foc_active=0, foc_i_dv=0, foc_i_d=0, fault=0, busy=0, commit_pending=0, overrun_cnt=0.
REQ-036 rst: all shadow and live parameters =0 (zero gains, zero max_v: safe output).
REQ-037 rst mid-BUSY abandons the cycle; subsequent foc_done ignored.

Structure
REQ-038 State encodings, cfg address constants and DONE_TIMEOUT default in shared package foc_sched_pkg.
REQ-039 Shadow/live register pair with commit in sub-module foc_param_bank; FSM, timer, overrun counter in foc_sched.

Verification
REQ-040 en=1, adc_dv with adc_d=48'h3FE8_402E_4028, foc_done 25 cycles later -> foc_i_dv one cycle after adc_dv with that data, busy high 25 cycles, state RUN.
REQ-041 Write p_gain=8000, commit during BUSY -> p_gain stays 0 until BUSY->RUN cycle, then 8000; commit_pending drops same cycle.
REQ-042 Three adc_dv pulses during one BUSY -> overrun_cnt=3, single foc_i_dv; OVR_W=2 with 5 overruns -> saturates at 3.
REQ-043 No foc_done after foc_i_dv -> fault=1 exactly DONE_TIMEOUT(64) cycles after BUSY entry, foc_active=0; en=0 -> IDLE, fault=0.
REQ-044 en dropped mid-BUSY, late foc_done -> IDLE, foc_active=0, no state change on foc_done; re-enable gives new foc_active rising edge.
REQ-045 rst asserted in BUSY with pending commit -> all outputs at reset values next cycle, live params 0, commit_pending=0.
